// File: rtl/mux_tree_pkg.sv
// Shared types and frame-layout helpers for the reconfigurable mux tree.
// MUX_TREE_OUTREG_EN adds a K-bit per-level output-register field to the frame.
package mux_tree_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cfg_state_e;

    function automatic int idx_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

    function automatic int cfg_w(input int k);
`ifdef MUX_TREE_OUTREG_EN
        return k * idx_w(k) + 2 * k;
`else
        return k * idx_w(k) + k;
`endif
    endfunction

    function automatic int sel_off(input int k, input int l);
        return l * idx_w(k);
    endfunction

    function automatic int outhi_off(input int k, input int l);
        return k * idx_w(k) + l;
    endfunction

    function automatic int reg_off(input int k, input int l);
        return k * idx_w(k) + k + l;
    endfunction

endpackage

// File: rtl/mux_tree_cfg_loader.sv
// Serial configuration loader: shadow shift register, saturating bit counter,
// IDLE/SHIFT FSM and the atomically committed active configuration.
module mux_tree_cfg_loader
    import mux_tree_pkg::*;
#(
    parameter int  K     = 3,
    localparam int CFG_W = cfg_w(K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             conf_in,
    output logic             conf_out,
    output logic [CFG_W-1:0] active,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int IDXW = idx_w(K);
    localparam int CW   = $clog2(CFG_W + 1);

    function automatic logic [CFG_W-1:0] reset_frame();
        logic [CFG_W-1:0] f;
        f = '0;
        for (int l = 0; l < K; l++) begin
            f[l*IDXW +: IDXW] = IDXW'(l);
        end
        return f;
    endfunction

    localparam logic [CFG_W-1:0] RESET_FRAME = reset_frame();

    cfg_state_e       state_q, state_d;
    logic [CFG_W-1:0] sr_q;
    logic [CFG_W-1:0] active_q;
    logic [CW-1:0]    cnt_q;
    logic             commit;
    logic             short_frame;

    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        short_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode) state_d = SHIFT;
            end
            SHIFT: begin
                if (!mode) begin
                    state_d = IDLE;
                    if (cnt_q >= CW'(CFG_W)) commit = 1'b1;
                    else                     short_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath keeps using active_q while sr_q shifts; only a full frame replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= RESET_FRAME;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_done <= commit;
            if (mode) begin
                sr_q <= {sr_q[CFG_W-2:0], conf_in};
                if (cnt_q != CW'(CFG_W)) cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (commit) active_q <= sr_q;
            if (commit)           cfg_err <= 1'b0;
            else if (short_frame) cfg_err <= 1'b1;
        end
    end

    assign conf_out = sr_q[CFG_W-1];
    assign active   = active_q;

endmodule

// File: rtl/mux_tree_lut_cfg.sv
// 2^K:1 mux tree with configurable per-level select routing and per-level taps.
// MUX_TREE_OUTREG_EN enables optional per-level output flops selected by the frame.
module mux_tree_lut_cfg
    import mux_tree_pkg::*;
#(
    parameter int  K = 3,
    localparam int N = 2 ** K
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] D,
    input  logic [K-1:0] S,
    output logic [K-1:0] M,
    input  logic         MODE,
    input  logic         CONFin,
    output logic         CONFout,
    output logic         CFG_DONE,
    output logic         CFG_ERR
);

    localparam int IDXW  = idx_w(K);
    localparam int CFG_W = cfg_w(K);
    localparam int W     = 2 * N - 1;

    logic [CFG_W-1:0] active;
    logic [W-1:0]     node;
    logic [K-1:0]     sel;
    logic [K-1:0]     m_comb;

    mux_tree_cfg_loader #(.K(K)) u_loader (
        .clk      (CLK),
        .reset    (RESET),
        .mode     (MODE),
        .conf_in  (CONFin),
        .conf_out (CONFout),
        .active   (active),
        .cfg_done (CFG_DONE),
        .cfg_err  (CFG_ERR)
    );

    // node holds every level back to back: D first, then level 0 outputs, level 1, ...
    assign node[N-1:0] = D;

    for (genvar l = 0; l < K; l++) begin : g_level
        localparam int IB  = 2 * N - ((2 * N) >> l);
        localparam int OB  = 2 * N - ((2 * N) >> (l + 1));
        localparam int CNT = N >> (l + 1);

        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] eff;

        assign idx    = active[sel_off(K, l) +: IDXW];
        assign eff    = (int'(idx) >= K) ? IDXW'(l) : idx;
        assign sel[l] = S[eff];

        for (genvar i = 0; i < CNT; i++) begin : g_mux
            assign node[OB+i] = sel[l] ? node[IB+2*i+1] : node[IB+2*i];
        end

        // At the root level first and last mux coincide, so OUT_HI has no effect there.
        assign m_comb[l] = active[outhi_off(K, l)] ? node[OB+CNT-1] : node[OB];
    end

`ifdef MUX_TREE_OUTREG_EN
    logic [K-1:0] m_q;
    logic [K-1:0] reg_en;

    for (genvar l = 0; l < K; l++) begin : g_reg_en
        assign reg_en[l] = active[reg_off(K, l)];
    end

    always_ff @(posedge CLK) begin
        if (RESET) m_q <= '0;
        else       m_q <= m_comb;
    end

    assign M = (reg_en & m_q) | (~reg_en & m_comb);
`else
    assign M = m_comb;
`endif

endmodule

// File: tb/tb_mux_tree_lut_cfg.sv
// Self-checking bench for mux_tree_lut_cfg (K=3): frame-level reference model
// compared every cycle, plus hand-computed directed checks.
module tb_mux_tree_lut_cfg;

    localparam int K = 3;
    localparam int N = 8;
`ifdef MUX_TREE_OUTREG_EN
    localparam int CFG_W = 12;
`else
    localparam int CFG_W = 9;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic         conf_in;
    logic [N-1:0] d;
    logic [K-1:0] s;
    logic [K-1:0] m;
    logic         conf_out;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    mux_tree_lut_cfg #(.K(K)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .D        (d),
        .S        (s),
        .M        (m),
        .MODE     (mode),
        .CONFin   (conf_in),
        .CONFout  (conf_out),
        .CFG_DONE (done),
        .CFG_ERR  (err)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: configuration as plain arrays, shift history as a bit queue.
    int               m_sel[3];
    logic [2:0]       m_oh;
    logic [2:0]       m_reg;
    logic [2:0]       m_prev;
    logic             mq[$];
    int               mcnt;
    bit               mshift;
    logic             e_done;
    logic             e_err;
    logic [CFG_W-1:0] mf;

    // Level-l tap reads D at (group base + offset), where offset bit j comes from the
    // select routed to level j.
    function automatic logic [2:0] tree_ref(input logic [7:0] dv, input logic [2:0] sv);
        logic [2:0] r;
        r = '0;
        for (int l = 0; l < 3; l++) begin
            int off, span, grp, e;
            off = 0;
            for (int j = 0; j <= l; j++) begin
                e = (m_sel[j] >= 3) ? j : m_sel[j];
                off += int'(sv[e]) << j;
            end
            span = 2 << l;
            grp  = (m_oh[l] && l < 2) ? (8 / span - 1) : 0;
            r[l] = dv[grp * span + off];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_prev = '0;
            mq.delete();
            mcnt   = 0;
            mshift = 1'b0;
            m_sel  = '{0, 1, 2};
            m_oh   = '0;
            m_reg  = '0;
            e_done = 1'b0;
            e_err  = 1'b0;
        end else begin
            m_prev = tree_ref(d, s);
            e_done = 1'b0;
            if (mode) begin
                mq.push_back(conf_in);
                if (mq.size() > CFG_W) void'(mq.pop_front());
                if (mcnt < CFG_W) mcnt++;
                mshift = 1'b1;
            end else if (mshift) begin
                mshift = 1'b0;
                if (mcnt >= CFG_W) begin
                    for (int i = 0; i < CFG_W; i++) mf[i] = mq[mq.size() - 1 - i];
                    for (int l = 0; l < 3; l++) begin
                        m_sel[l] = int'(mf[2*l +: 2]);
                        m_oh[l]  = mf[6 + l];
`ifdef MUX_TREE_OUTREG_EN
                        m_reg[l] = mf[9 + l];
`endif
                    end
                    e_done = 1'b1;
                    e_err  = 1'b0;
                end else begin
                    e_err = 1'b1;
                end
                mcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] comb, em;
            logic       eco;
            comb = tree_ref(d, s);
            em   = (m_reg & m_prev) | (~m_reg & comb);
            eco  = (mq.size() == CFG_W) ? mq[0] : 1'b0;
            check("model_m", m, em);
            check("model_done", done, e_done);
            check("model_err", err, e_err);
            check("model_confout", conf_out, eco);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [2*CFG_W-1:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mode    = 1'b1;
            conf_in = f[i];
            tick();
        end
        mode    = 1'b0;
        conf_in = 1'b0;
    endtask

    function automatic logic [CFG_W-1:0] make_frame(input int s0, input int s1, input int s2,
                                                     input logic [2:0] oh);
        logic [CFG_W-1:0] f;
        logic [1:0]       a, b, c;
        a = s0[1:0];
        b = s1[1:0];
        c = s2[1:0];
        f = '0;
        f[1:0] = a;
        f[3:2] = b;
        f[5:4] = c;
        f[8:6] = oh;
        return f;
    endfunction

    logic [CFG_W-1:0]   fa, fb, fr;
    logic [2*CFG_W-1:0] seq;
    logic [7:0]         dvec[4];

    initial begin
        rst = 1'b1; mode = 1'b0; conf_in = 1'b0; d = 8'hA6; s = 3'b101;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        check("t1_m2_reset", m[2], 1'b1);
        check("t1_done_reset", done, 1'b0);
        check("t1_err_reset", err, 1'b0);
        check("t1_confout_reset", conf_out, 1'b0);

        // all levels routed to S[0]
        tick();
        d = 8'h80; s = 3'b001;
        shift_bits({{CFG_W{1'b0}}, make_frame(0, 0, 0, 3'b000)}, CFG_W);
        at_neg();
        check("t2_m2_during_shift", m[2], 1'b0);
        tick();
        at_neg();
        check("t2_done_pulse", done, 1'b1);
        check("t2_m2_after_commit", m[2], 1'b1);
        tick();
        at_neg();
        check("t2_done_cleared", done, 1'b0);

        // short frame, then a good one
        tick();
        shift_bits({{(2*CFG_W-5){1'b0}}, 5'b10101}, 5);
        tick();
        at_neg();
        check("t3_err_short", err, 1'b1);
        check("t3_no_done", done, 1'b0);
        check("t3_m2_unchanged", m[2], 1'b1);
        tick();
        shift_bits({{CFG_W{1'b0}}, make_frame(0, 1, 2, 3'b000)}, CFG_W);
        tick();
        at_neg();
        check("t3_done_good", done, 1'b1);
        check("t3_err_cleared", err, 1'b0);
        check("t3_m2_default", m[2], 1'b0);

        // chained 2-frame shift: CONFout replays the first frame
        fa  = make_frame(1, 2, 3, 3'b101);
        fb  = make_frame(0, 3, 2, 3'b001);
        seq = {fa, fb};
        tick();
        for (int t = 0; t < 2 * CFG_W; t++) begin
            mode    = 1'b1;
            conf_in = seq[2*CFG_W-1-t];
            tick();
            at_neg();
            if (t + 1 >= CFG_W) check("t4_confout_replay", conf_out, seq[2*CFG_W-1-(t+1-CFG_W)]);
        end
        mode = 1'b0; conf_in = 1'b0;
        tick();
        at_neg();
        check("t4_done_chain", done, 1'b1);

        // frame fb: SEL_IDX[1]=3 (-> S[1]), OUT_HI[0]=1
        tick();
        d = 8'h40; s = 3'b000;
        at_neg();
        check("t5_m0_s0_lo", m[0], 1'b1);
        tick();
        s = 3'b001;
        at_neg();
        check("t5_m0_s0_hi", m[0], 1'b0);
        tick();
        s = 3'b110;
        at_neg();
        check("t5_m2_s6", m[2], 1'b1);

        dvec = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                tick();
                d = dvec[i];
                s = 3'(j);
            end
        end

        // reset in the middle of a shift, with MODE still high
        tick();
        shift_bits({{(2*CFG_W-3){1'b0}}, 3'b110}, 3);
        tick();
        at_neg();
        check("t5_err_before_reset", err, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            mode = 1'b1; conf_in = 1'b1;
            tick();
        end
        rst = 1'b1; d = 8'h01; s = 3'b000;
        tick();
        rst = 1'b0;
        at_neg();
        check("t5_err_after_reset", err, 1'b0);
        check("t5_confout_after_reset", conf_out, 1'b0);
        check("t5_m0_default", m[0], 1'b1);
        tick();
        mode = 1'b0; conf_in = 1'b0;
        tick();
        at_neg();
        check("t5_err_short_after_reset", err, 1'b1);
        tick();
        shift_bits({{CFG_W{1'b0}}, make_frame(2, 1, 0, 3'b011)}, CFG_W);
        tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            d = 8'hB4;
            s = 3'(j);
        end

`ifdef MUX_TREE_OUTREG_EN
        // REG[2]=1: root tap delayed by one clock, lower taps combinational
        fr     = make_frame(0, 1, 2, 3'b000);
        fr[11] = 1'b1;
        tick();
        shift_bits({{CFG_W{1'b0}}, fr}, CFG_W);
        tick();
        d = 8'h00; s = 3'b000;
        tick();
        tick();
        d = 8'hFF;
        at_neg();
        check("t6_m2_lags", m[2], 1'b0);
        check("t6_m0_immediate", m[0], 1'b1);
        check("t6_m1_immediate", m[1], 1'b1);
        tick();
        at_neg();
        check("t6_m2_follows", m[2], 1'b1);
`else
        fr = '0;
`endif

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
